// File: rtl/alu_pipelined_pkg.sv
// Shared ALUctl field encodings (sail-core) and pipeline depth limits for the execute-stage ALU.
package alu_pipelined_pkg;

  localparam int CTL_W = 7;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SRL   = 4'b0011,
    ALU_SLL   = 4'b0100,
    ALU_SRA   = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_SLT   = 4'b0111,
    ALU_XOR   = 4'b1000,
    ALU_CSRRW = 4'b1001,
    ALU_CSRRS = 4'b1010,
    ALU_CSRRC = 4'b1011
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_BLTU = 3'b101,
    BR_BGEU = 3'b110
  } br_type_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 3;

endpackage

// File: rtl/alu_pipelined_compute.sv
// Purely combinational ALU core: {ctl, a, b} -> {result, branch}, WIDTH-parametrised.
module alu_compute
  import alu_pipelined_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [CTL_W-1:0] ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             branch
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    case (ctl[3:0])
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a + ~b + WIDTH'(1);
      ALU_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $signed(a) >>> shamt;
      ALU_XOR:   result = a ^ b;
      ALU_CSRRW: result = a;
      ALU_CSRRS: result = a | b;
      ALU_CSRRC: result = ~a & b;
      default:   result = '0;
    endcase
  end

  // Branch decision looks only at the issued operands, never at the op field.
  always_comb begin
    branch = 1'b0;
    case (ctl[6:4])
      BR_BEQ:  branch = (a == b);
      BR_BNE:  branch = (a != b);
      BR_BLT:  branch = ($signed(a) <  $signed(b));
      BR_BGE:  branch = ($signed(a) >= $signed(b));
      BR_BLTU: branch = (a <  b);
      BR_BGEU: branch = (a >= b);
      default: branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_pipelined.sv
// Handshaked execute-stage ALU: LATENCY register stages with valid/ready backpressure, flush and tag passthrough.
module alu_pipelined
  import alu_pipelined_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTL_W-1:0] in_ctl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_branch,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  // With one stage the ALU sits in front of s1; otherwise s1 holds raw operands.
  localparam int FIRST = (LATENCY == 1) ? 1 : 2;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX || WIDTH < 8) begin : g_bad_params
    $error("alu_pipelined: illegal LATENCY or WIDTH");
  end

  logic [LATENCY:1]     v;
  logic [LATENCY:1]     adv;
  logic [LATENCY:1]     en;
  logic [LATENCY:1]     mv;
  logic                 accept;
  logic [CTL_W-1:0]     comp_ctl;
  logic [WIDTH-1:0]     comp_a;
  logic [WIDTH-1:0]     comp_b;
  logic [TAG_W-1:0]     comp_tag;
  logic [WIDTH-1:0]     comp_result;
  logic                 comp_branch;
  logic [WIDTH-1:0]     res_q [FIRST:LATENCY];
  logic [TAG_W-1:0]     tag_q [FIRST:LATENCY];
  logic [LATENCY:FIRST] br_q;

  // A stage is free to load when empty or when its occupant moves on this edge.
  assign adv[LATENCY] = v[LATENCY] & out_ready;
  for (genvar k = 1; k < LATENCY; k++) begin : g_adv
    assign adv[k] = v[k] & (~v[k+1] | adv[k+1]);
  end

  assign en       = ~v | adv;
  assign in_ready = ~flush & en[1];
  assign accept   = in_valid & in_ready;

  assign mv[1] = accept;
  for (genvar k = 2; k <= LATENCY; k++) begin : g_mv
    assign mv[k] = adv[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      v <= (v & ~en) | (mv & en);
    end
  end

  if (LATENCY == 1) begin : g_direct
    assign comp_ctl = in_ctl;
    assign comp_a   = in_a;
    assign comp_b   = in_b;
    assign comp_tag = in_tag;
  end else begin : g_issue_reg
    logic [CTL_W-1:0] ctl_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [TAG_W-1:0] t_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctl_q <= '0;
        a_q   <= '0;
        b_q   <= '0;
        t_q   <= '0;
      end else if (accept) begin
        ctl_q <= in_ctl;
        a_q   <= in_a;
        b_q   <= in_b;
        t_q   <= in_tag;
      end
    end

    assign comp_ctl = ctl_q;
    assign comp_a   = a_q;
    assign comp_b   = b_q;
    assign comp_tag = t_q;
  end

  alu_compute #(.WIDTH(WIDTH)) u_compute (
    .ctl    (comp_ctl),
    .a      (comp_a),
    .b      (comp_b),
    .result (comp_result),
    .branch (comp_branch)
  );

  // Result stages only load when an op actually moves in, so a stalled output holds still.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = FIRST; k <= LATENCY; k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end
      br_q <= '0;
    end else if (!flush) begin
      if (mv[FIRST]) begin
        res_q[FIRST] <= comp_result;
        br_q[FIRST]  <= comp_branch;
        tag_q[FIRST] <= comp_tag;
      end
      for (int k = FIRST + 1; k <= LATENCY; k++) begin
        if (mv[k]) begin
          res_q[k] <= res_q[k-1];
          br_q[k]  <= br_q[k-1];
          tag_q[k] <= tag_q[k-1];
        end
      end
    end
  end

  assign out_valid  = v[LATENCY];
  assign out_result = res_q[LATENCY];
  assign out_branch = br_q[LATENCY];
  assign out_tag    = tag_q[LATENCY];
  assign out_zero   = (res_q[LATENCY] == '0);

endmodule

// File: tb/tb_alu_pipelined.sv
// Self-checking bench for alu_pipelined: main W32/L2 instance plus L1, L3 and W64 variants on shared stimulus.
module tb_alu_pipelined;

  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_SRL = 4'd3,
                         OP_SLL = 4'd4, OP_SRA = 4'd5, OP_SUB = 4'd6, OP_SLT = 4'd7,
                         OP_XOR = 4'd8, OP_CSRRW = 4'd9, OP_CSRRS = 4'd10, OP_CSRRC = 4'd11;
  localparam logic [2:0] B_NONE = 3'd0, B_BEQ = 3'd1, B_BNE = 3'd2, B_BLT = 3'd3,
                         B_BGE = 3'd4, B_BLTU = 3'd5, B_BGEU = 3'd6;
  localparam int NINST = 4;

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [6:0]  in_ctl = '0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [4:0]  in_tag = '0;

  logic [NINST-1:0] rdy, ov, obr, oz;
  logic [31:0] r0, r1, r2;
  logic [63:0] r3;
  logic [4:0]  t0, t1, t2, t3;
  logic [63:0] ores [NINST];
  logic [4:0]  otag [NINST];

  int checks = 0;
  int passed = 0;
  int lat_of [NINST] = '{2, 1, 3, 2};
  int wid_of [NINST] = '{32, 32, 32, 64};

  always #5 clk = ~clk;

  assign ores[0] = {32'b0, r0};
  assign ores[1] = {32'b0, r1};
  assign ores[2] = {32'b0, r2};
  assign ores[3] = r3;
  assign otag[0] = t0;
  assign otag[1] = t1;
  assign otag[2] = t2;
  assign otag[3] = t3;

  alu_pipelined #(.WIDTH(32), .LATENCY(2), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_ctl(in_ctl), .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_tag(in_tag),
    .out_valid(ov[0]), .out_ready(out_ready), .out_result(r0), .out_branch(obr[0]),
    .out_zero(oz[0]), .out_tag(t0));

  alu_pipelined #(.WIDTH(32), .LATENCY(1), .TAG_W(5)) dut_l1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_ctl(in_ctl), .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_tag(in_tag),
    .out_valid(ov[1]), .out_ready(out_ready), .out_result(r1), .out_branch(obr[1]),
    .out_zero(oz[1]), .out_tag(t1));

  alu_pipelined #(.WIDTH(32), .LATENCY(3), .TAG_W(5)) dut_l3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_ctl(in_ctl), .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_tag(in_tag),
    .out_valid(ov[2]), .out_ready(out_ready), .out_result(r2), .out_branch(obr[2]),
    .out_zero(oz[2]), .out_tag(t2));

  alu_pipelined #(.WIDTH(64), .LATENCY(2), .TAG_W(5)) dut_w64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_ctl(in_ctl), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(ov[3]), .out_ready(out_ready), .out_result(r3), .out_branch(obr[3]),
    .out_zero(oz[3]), .out_tag(t3));

  // Reference ALU from the arithmetic rules; returns {branch, result} for a given width.
  function automatic logic [64:0] ref_alu(input logic [6:0] ctl, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input int w);
    logic [63:0] mask, a, b, r;
    longint      sa, sb;
    int          sh;
    logic        br;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a = a_in & mask;
    b = b_in & mask;
    sa = (w == 64) ? longint'(a) : longint'($signed(a[31:0]));
    sb = (w == 64) ? longint'(b) : longint'($signed(b[31:0]));
    sh = int'(b % 64'(w));
    case (ctl[3:0])
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_SLT:   r = (sa < sb) ? 64'd1 : 64'd0;
      OP_SLL:   r = a << sh;
      OP_SRL:   r = a >> sh;
      OP_SRA:   r = 64'(sa >>> sh);
      OP_XOR:   r = a ^ b;
      OP_CSRRW: r = a;
      OP_CSRRS: r = a | b;
      OP_CSRRC: r = ~a & b;
      default:  r = 64'd0;
    endcase
    r = r & mask;
    case (ctl[6:4])
      B_BEQ:   br = (a == b);
      B_BNE:   br = (a != b);
      B_BLT:   br = (sa < sb);
      B_BGE:   br = (sa >= sb);
      B_BLTU:  br = (a < b);
      B_BGEU:  br = (a >= b);
      default: br = 1'b0;
    endcase
    return {br, r};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NINST; i++) begin
      checks++; if (ov[i] !== 1'b0) $display("[TB] FAIL reset_valid[%0d]: got %b want 0", i, ov[i]); else passed++;
      checks++; if (ores[i] !== 64'd0) $display("[TB] FAIL reset_result[%0d]: got %h want 0", i, ores[i]); else passed++;
      checks++; if (oz[i] !== 1'b1) $display("[TB] FAIL reset_zero[%0d]: got %b want 1", i, oz[i]); else passed++;
      checks++; if (obr[i] !== 1'b0 || otag[i] !== 5'd0) $display("[TB] FAIL reset_br_tag[%0d]: got %b/%0d want 0/0", i, obr[i], otag[i]); else passed++;
    end
    checks++; if (rdy[0] !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", rdy[0]); else passed++;
    rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_ctl = {B_NONE, OP_ADD}; in_a = 64'd1; in_b = 64'd2; in_tag = 5'd1;
    @(negedge clk);
    in_a = 64'd3; in_tag = 5'd2;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (ov[0] !== 1'b1) $display("[TB] FAIL midrst_filled: got %b want 1", ov[0]); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (ov[0] !== 1'b0) $display("[TB] FAIL midrst_valid: got %b want 0", ov[0]); else passed++;
    checks++; if (r0 !== 32'd0) $display("[TB] FAIL midrst_result: got %h want 0", r0); else passed++;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_ctl = {B_NONE, OP_ADD}; in_a = 64'd20; in_b = 64'd22; in_tag = 5'd7;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (ov[0] !== 1'b0) $display("[TB] FAIL postrst_early: got %b want 0", ov[0]); else passed++;
    @(negedge clk);
    checks++; if (ov[0] !== 1'b1 || r0 !== 32'd42 || t0 !== 5'd7)
      $display("[TB] FAIL postrst_op: got v=%b r=%0d t=%0d want v=1 r=42 t=7", ov[0], r0, t0); else passed++;
    @(negedge clk);
  endtask

  task automatic test_add();
    in_valid = 1'b1; in_ctl = {B_NONE, OP_ADD}; in_a = 64'd5; in_b = 64'd7; in_tag = 5'd3;
    #1;
    checks++; if (rdy[0] !== 1'b1) $display("[TB] FAIL add_ready: got %b want 1", rdy[0]); else passed++;
    @(negedge clk);
    checks++; if (ov[0] !== 1'b0) $display("[TB] FAIL add_latency: got %b want 0", ov[0]); else passed++;
    in_a = 64'hFFFF_FFFF; in_b = 64'd1; in_tag = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (ov[0] !== 1'b1 || r0 !== 32'd12 || t0 !== 5'd3 || oz[0] !== 1'b0)
      $display("[TB] FAIL add_5_7: got v=%b r=%0d t=%0d z=%b want v=1 r=12 t=3 z=0", ov[0], r0, t0, oz[0]); else passed++;
    @(negedge clk);
    checks++; if (ov[0] !== 1'b1 || r0 !== 32'd0 || t0 !== 5'd4 || oz[0] !== 1'b1)
      $display("[TB] FAIL add_wrap: got v=%b r=%h t=%0d z=%b want v=1 r=0 t=4 z=1", ov[0], r0, t0, oz[0]); else passed++;
    @(negedge clk);
    checks++; if (ov[0] !== 1'b0) $display("[TB] FAIL add_drain: got %b want 0", ov[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [6:0]  c [3] = '{{B_NONE, OP_SUB}, {B_NONE, OP_SRA}, {B_NONE, OP_SLL}};
    logic [63:0] a [3] = '{64'd10, 64'h8000_0000, 64'd1};
    logic [63:0] b [3] = '{64'd3, 64'd4, 64'd31};
    logic [31:0] e [3] = '{32'd7, 32'hF800_0000, 32'h8000_0000};
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        checks++; if (ov[0] !== 1'b1 || r0 !== e[i-2] || t0 !== 5'(10 + i - 2))
          $display("[TB] FAIL b2b_%0d: got v=%b r=%h t=%0d want v=1 r=%h t=%0d", i - 2, ov[0], r0, t0, e[i-2], 10 + i - 2);
        else passed++;
      end
      if (i < 3) begin
        in_valid = 1'b1; in_ctl = c[i]; in_a = a[i]; in_b = b[i]; in_tag = 5'(10 + i);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t x;
    int   sent = 0;
    int   cyc;
    logic exp_rdy;
    for (cyc = 0; cyc < 40 && (sent < 4 || q.size() > 0); cyc++) begin
      out_ready = (cyc >= 6);
      exp_rdy = (q.size() < 2) || out_ready;
      if (ov[0]) begin
        checks++;
        if (q.size() == 0) $display("[TB] FAIL bp_spurious: got tag %0d want none", t0);
        else if ({r0, obr[0], t0} !== q[0])
          $display("[TB] FAIL bp_order: got r=%h t=%0d want r=%h t=%0d", r0, t0, q[0].res, q[0].tag);
        else passed++;
        if (out_ready && q.size() > 0) void'(q.pop_front());
      end
      if (sent < 4) begin
        in_valid = 1'b1; in_ctl = {B_NONE, OP_ADD};
        in_a = 64'(100 * (sent + 1)); in_b = 64'(sent); in_tag = 5'(16 + sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++; if (rdy[0] !== exp_rdy) $display("[TB] FAIL bp_in_ready cyc%0d: got %b want %b", cyc, rdy[0], exp_rdy); else passed++;
      if (in_valid && rdy[0]) begin
        x.res = 32'(100 * (sent + 1) + sent); x.br = 1'b0; x.tag = 5'(16 + sent);
        q.push_back(x);
        sent++;
      end
      @(negedge clk);
    end
    checks++; if (sent != 4 || q.size() != 0)
      $display("[TB] FAIL bp_complete: got sent=%0d left=%0d want sent=4 left=0", sent, q.size()); else passed++;
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_ctl = {B_NONE, OP_ADD}; in_a = 64'd1; in_b = 64'd1; in_tag = 5'd20;
    @(negedge clk);
    in_tag = 5'd21;
    @(negedge clk);
    flush = 1'b1; in_tag = 5'd22;
    #1;
    checks++; if (rdy[0] !== 1'b0) $display("[TB] FAIL flush_in_ready: got %b want 0", rdy[0]); else passed++;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (ov[0] !== 1'b0) $display("[TB] FAIL flush_leak cyc%0d: got valid tag %0d want none", i, t0); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        x;
    logic [64:0] m;
    int          sent = 0;
    int          cyc;
    logic        exp_rdy;
    for (cyc = 0; cyc < 3000 && (sent < 150 || q.size() > 0); cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      exp_rdy = (q.size() < 2) || out_ready;
      if (ov[0]) begin
        checks++;
        if (q.size() == 0) $display("[TB] FAIL rnd_spurious: got tag %0d want none", t0);
        else if ({r0, obr[0], t0} !== q[0] || oz[0] !== (q[0].res == 32'd0))
          $display("[TB] FAIL rnd_result: got r=%h b=%b t=%0d z=%b want r=%h b=%b t=%0d", r0, obr[0], t0, oz[0], q[0].res, q[0].br, q[0].tag);
        else passed++;
        if (out_ready && q.size() > 0) void'(q.pop_front());
      end
      if (sent < 150 && $urandom_range(0, 4) != 0) begin
        in_valid = 1'b1;
        in_ctl = 7'($urandom_range(0, 127));
        in_a = {32'd0, ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom)};
        in_b = {32'd0, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom)};
        in_tag = 5'($urandom_range(0, 31));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++; if (rdy[0] !== exp_rdy) $display("[TB] FAIL rnd_in_ready cyc%0d: got %b want %b", cyc, rdy[0], exp_rdy); else passed++;
      if (in_valid && rdy[0]) begin
        m = ref_alu(in_ctl, in_a, in_b, 32);
        x.res = m[31:0]; x.br = m[64]; x.tag = in_tag;
        q.push_back(x);
        sent++;
      end
      @(negedge clk);
    end
    checks++; if (sent != 150 || q.size() != 0)
      $display("[TB] FAIL rnd_complete: got sent=%0d left=%0d want sent=150 left=0", sent, q.size()); else passed++;
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_branch();
    logic [6:0]  fc [5] = '{{B_BEQ, OP_ADD}, {B_BLT, OP_SUB}, {B_BLTU, OP_SLT}, {B_BGEU, OP_SRA}, {B_BNE, OP_XOR}};
    logic [63:0] fa [5] = '{64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 64'd5};
    logic [63:0] fb [5] = '{64'd9, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    logic        fbr [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [64:0] m;
    int          first [NINST];
    logic [63:0] gr [NINST];
    logic        gb [NINST];
    logic [4:0]  gt [NINST];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int v = 0; v < 25; v++) begin
      in_valid = 1'b1; in_tag = 5'(v);
      if (v < 5) begin
        in_ctl = fc[v]; in_a = fa[v]; in_b = fb[v];
      end else begin
        in_ctl = 7'($urandom_range(0, 127));
        in_a = {32'($urandom), 32'($urandom)};
        in_b = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 70)) : {32'($urandom), 32'($urandom)};
      end
      for (int i = 0; i < NINST; i++) first[i] = -1;
      #1;
      for (int i = 0; i < NINST; i++) begin
        checks++; if (rdy[i] !== 1'b1) $display("[TB] FAIL br_ready[%0d] v%0d: got %b want 1", i, v, rdy[i]); else passed++;
      end
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < NINST; i++) begin
          if (ov[i] && first[i] < 0) begin
            first[i] = j; gr[i] = ores[i]; gb[i] = obr[i]; gt[i] = otag[i];
          end
        end
      end
      for (int i = 0; i < NINST; i++) begin
        m = ref_alu(in_ctl, in_a, in_b, wid_of[i]);
        checks++; if (first[i] != lat_of[i] - 1)
          $display("[TB] FAIL br_latency[%0d] v%0d: got %0d want %0d", i, v, first[i], lat_of[i] - 1); else passed++;
        checks++; if (gr[i] !== m[63:0] || gt[i] !== 5'(v))
          $display("[TB] FAIL br_result[%0d] v%0d: got r=%h t=%0d want r=%h t=%0d", i, v, gr[i], gt[i], m[63:0], v); else passed++;
        checks++; if (gb[i] !== m[64])
          $display("[TB] FAIL br_taken[%0d] v%0d: got %b want %b", i, v, gb[i], m[64]); else passed++;
        if (v < 5) begin
          checks++; if (gb[i] !== fbr[v])
            $display("[TB] FAIL br_fixed[%0d] v%0d: got %b want %b", i, v, gb[i], fbr[v]); else passed++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    test_branch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
